// File: rtl/iob_sync_asym_fifo_pkg.sv
// Shared helpers for the asymmetric FIFO: unit width, width ratios and
// sub-word lane placement inside a wide word.
package iob_sync_asym_fifo_pkg;

   function automatic int min_w(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int ratio(input int w, input int unit_w);
      return w / unit_w;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Bit offset of the i-th MIN_W unit within a word of 'rat' units.
   function automatic int lane_off(input int i, input int rat, input int unit_w,
                                   input int big_endian);
      return (big_endian != 0) ? (rat - 1 - i) * unit_w : i * unit_w;
   endfunction

endpackage

// File: rtl/iob_asym_regfile.sv
// Unit-addressed storage with a W_RATIO-unit write port and a registered
// R_RATIO-unit read port.
module iob_asym_regfile
   import iob_sync_asym_fifo_pkg::*;
#(
   parameter int MIN_W      = 8,
   parameter int W_RATIO    = 4,
   parameter int R_RATIO    = 1,
   parameter int ADDR_W     = 4,
   parameter int BIG_ENDIAN = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          wptr,
   input  logic [W_RATIO*MIN_W-1:0]   wdata,
   input  logic                       re,
   input  logic [ADDR_W-1:0]          rptr,
   output logic [R_RATIO*MIN_W-1:0]   rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [MIN_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < W_RATIO; i++) begin
            mem[wptr + ADDR_W'(i)] <= wdata[lane_off(i, W_RATIO, MIN_W, BIG_ENDIAN) +: MIN_W];
         end
      end
   end

   // Read word is registered; it only changes on an accepted read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         for (int i = 0; i < R_RATIO; i++) begin
            rdata[lane_off(i, R_RATIO, MIN_W, BIG_ENDIAN) +: MIN_W] <= mem[rptr + ADDR_W'(i)];
         end
      end
   end

endmodule

// File: rtl/iob_sync_asym_fifo.sv
// Single-clock FIFO with independent write/read widths, level-based flags,
// programmable thresholds and registered overflow/underflow pulses.
module iob_sync_asym_fifo
   import iob_sync_asym_fifo_pkg::*;
#(
   parameter int W_DATA_W   = 32,
   parameter int R_DATA_W   = 8,
   parameter int ADDR_W     = 4,
   parameter int BIG_ENDIAN = 0,
   parameter int AF_THR     = (1 << ADDR_W) - 4,
   parameter int AE_THR     = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                write_en,
   input  logic [W_DATA_W-1:0] data_in,
   input  logic                read_en,
   output logic [R_DATA_W-1:0] data_out,
   output logic                full,
   output logic                empty,
   output logic                almost_full,
   output logic                almost_empty,
   output logic                overflow,
   output logic                underflow,
   output logic [ADDR_W:0]     fifo_level
);

   localparam int MIN_W   = min_w(W_DATA_W, R_DATA_W);
   localparam int W_RATIO = ratio(W_DATA_W, MIN_W);
   localparam int R_RATIO = ratio(R_DATA_W, MIN_W);
   localparam int DEPTH   = 1 << ADDR_W;

   localparam logic [ADDR_W:0] W_INC    = (ADDR_W+1)'(W_RATIO);
   localparam logic [ADDR_W:0] R_INC    = (ADDR_W+1)'(R_RATIO);
   localparam logic [ADDR_W:0] FULL_LIM = (ADDR_W+1)'(DEPTH - W_RATIO);
   localparam logic [ADDR_W:0] AF_LIM   = (ADDR_W+1)'(AF_THR);
   localparam logic [ADDR_W:0] AE_LIM   = (ADDR_W+1)'(AE_THR);

   if ((W_DATA_W % MIN_W != 0) || (R_DATA_W % MIN_W != 0) ||
       ((1 << clog2(W_RATIO)) != W_RATIO) || ((1 << clog2(R_RATIO)) != R_RATIO)) begin : g_bad_ratio
      $error("iob_sync_asym_fifo: width ratio must be a power of two");
   end
   if ((AF_THR > DEPTH) || (AE_THR >= DEPTH)) begin : g_bad_thr
      $error("iob_sync_asym_fifo: threshold out of range");
   end
   if ((W_RATIO > DEPTH) || (R_RATIO > DEPTH)) begin : g_bad_depth
      $error("iob_sync_asym_fifo: depth smaller than one word");
   end

   logic [ADDR_W-1:0] wptr, rptr;
   logic [ADDR_W:0]   level;
   logic              wr_acc, rd_acc;

   // Flags come from the registered level only, so a same-cycle read never
   // frees room for a write and a same-cycle write never feeds a read.
   assign full         = level > FULL_LIM;
   assign empty        = level < R_INC;
   assign almost_full  = level >= AF_LIM;
   assign almost_empty = level <= AE_LIM;
   assign fifo_level   = level;
   assign wr_acc       = write_en && !full;
   assign rd_acc       = read_en && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr + W_INC[ADDR_W-1:0];
         if (rd_acc) rptr <= rptr + R_INC[ADDR_W-1:0];
         level     <= level + (wr_acc ? W_INC : '0) - (rd_acc ? R_INC : '0);
         overflow  <= write_en && full;
         underflow <= read_en && empty;
      end
   end

   iob_asym_regfile #(
      .MIN_W      (MIN_W),
      .W_RATIO    (W_RATIO),
      .R_RATIO    (R_RATIO),
      .ADDR_W     (ADDR_W),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .wptr  (wptr),
      .wdata (data_in),
      .re    (rd_acc),
      .rptr  (rptr),
      .rdata (data_out)
   );

endmodule

// File: tb/tb_iob_sync_asym_fifo.sv
// Directed bench: a 32->8 little-endian FIFO and an 8->32 big-endian FIFO.
module tb_iob_sync_asym_fifo;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A: 32-bit write, 8-bit read, little-endian lanes.
   logic        write_en_a = 1'b0, read_en_a = 1'b0;
   logic [31:0] data_in_a = '0;
   logic [7:0]  data_out_a;
   logic        full_a, empty_a, af_a, ae_a, ov_a, uf_a;
   logic [4:0]  level_a;

   // Instance B: 8-bit write, 32-bit read, big-endian lanes.
   logic        write_en_b = 1'b0, read_en_b = 1'b0;
   logic [7:0]  data_in_b = '0;
   logic [31:0] data_out_b;
   logic        full_b, empty_b, af_b, ae_b, ov_b, uf_b;
   logic [4:0]  level_b;

   int total = 0;
   int bad   = 0;

   iob_sync_asym_fifo #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4), .BIG_ENDIAN(0),
                        .AF_THR(12), .AE_THR(4)) dut (
      .clk(clk), .rst(rst), .write_en(write_en_a), .data_in(data_in_a),
      .read_en(read_en_a), .data_out(data_out_a), .full(full_a), .empty(empty_a),
      .almost_full(af_a), .almost_empty(ae_a), .overflow(ov_a), .underflow(uf_a),
      .fifo_level(level_a));

   iob_sync_asym_fifo #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4), .BIG_ENDIAN(1),
                        .AF_THR(12), .AE_THR(4)) dut_b (
      .clk(clk), .rst(rst), .write_en(write_en_b), .data_in(data_in_b),
      .read_en(read_en_b), .data_out(data_out_b), .full(full_b), .empty(empty_b),
      .almost_full(af_b), .almost_empty(ae_b), .overflow(ov_b), .underflow(uf_b),
      .fifo_level(level_b));

   function automatic logic [31:0] w4(input int b);
      return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
   endfunction

   // Called 1 time unit after a rising edge; returns 1 time unit after the next.
   task automatic step_a(input logic we, input logic [31:0] d, input logic re);
      write_en_a = we; data_in_a = d; read_en_a = re;
      @(posedge clk); #1;
      write_en_a = 1'b0; read_en_a = 1'b0;
   endtask

   task automatic step_b(input logic we, input logic [7:0] d, input logic re);
      write_en_b = we; data_in_b = d; read_en_b = re;
      @(posedge clk); #1;
      write_en_b = 1'b0; read_en_b = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      total++; if (data_out_a !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out_a); end
      total++; if (level_a !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level_a); end
      total++; if ({empty_a, full_a, ae_a, af_a, ov_a, uf_a} !== 6'b101000) begin
         bad++; $display("FAIL reset_flags got=%b exp=101000", {empty_a, full_a, ae_a, af_a, ov_a, uf_a}); end
      total++; if (data_out_b !== 32'h0 || level_b !== 5'd0 || empty_b !== 1'b1) begin
         bad++; $display("FAIL reset_b got=%h/%0d/%b exp=0/0/1", data_out_b, level_b, empty_b); end
   endtask

   task automatic test_fill_drain();
      logic [4:0] lvl_t [4] = '{5'd4, 5'd8, 5'd12, 5'd16};
      logic [2:0] fl_t  [4] = '{3'b010, 3'b000, 3'b001, 3'b101}; // {full, ae, af}
      for (int k = 0; k < 4; k++) begin
         step_a(1'b1, w4(4 * k), 1'b0);
         total++; if (level_a !== lvl_t[k]) begin bad++; $display("FAIL fill_level k=%0d got=%0d exp=%0d", k, level_a, lvl_t[k]); end
         total++; if ({full_a, ae_a, af_a} !== fl_t[k]) begin
            bad++; $display("FAIL fill_flags k=%0d got=%b exp=%b", k, {full_a, ae_a, af_a}, fl_t[k]); end
      end
      for (int i = 0; i < 16; i++) begin
         step_a(1'b0, 32'h0, 1'b1);
         total++; if (data_out_a !== 8'(i) || level_a !== 5'(15 - i)) begin
            bad++; $display("FAIL drain i=%0d got=%h/%0d exp=%h/%0d", i, data_out_a, level_a, 8'(i), 15 - i); end
      end
      total++; if (empty_a !== 1'b1 || ae_a !== 1'b1 || full_a !== 1'b0) begin
         bad++; $display("FAIL drain_flags got=%b%b%b exp=110", empty_a, ae_a, full_a); end
   endtask

   task automatic test_overflow_underflow();
      for (int k = 0; k < 4; k++) step_a(1'b1, w4(8'h10 + 4 * k), 1'b0);
      total++; if (full_a !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", full_a); end
      step_a(1'b1, 32'hDEADBEEF, 1'b1);
      total++; if (ov_a !== 1'b1 || level_a !== 5'd15 || data_out_a !== 8'h10) begin
         bad++; $display("FAIL ovf_pulse got=%b/%0d/%h exp=1/15/10", ov_a, level_a, data_out_a); end
      step_a(1'b0, 32'h0, 1'b0);
      total++; if (ov_a !== 1'b0 || level_a !== 5'd15) begin
         bad++; $display("FAIL ovf_clear got=%b/%0d exp=0/15", ov_a, level_a); end
      for (int i = 0; i < 15; i++) begin
         step_a(1'b0, 32'h0, 1'b1);
         total++; if (data_out_a !== 8'(8'h11 + i)) begin
            bad++; $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, data_out_a, 8'(8'h11 + i)); end
      end
      step_a(1'b0, 32'h0, 1'b1);
      total++; if (uf_a !== 1'b1 || data_out_a !== 8'h1F || level_a !== 5'd0) begin
         bad++; $display("FAIL udf_pulse got=%b/%h/%0d exp=1/1f/0", uf_a, data_out_a, level_a); end
      step_a(1'b0, 32'h0, 1'b0);
      total++; if (uf_a !== 1'b0 || data_out_a !== 8'h1F) begin
         bad++; $display("FAIL udf_clear got=%b/%h exp=0/1f", uf_a, data_out_a); end
   endtask

   task automatic test_wraparound();
      int n = 8'h40;
      int e = 8'h40;
      for (int r = 0; r < 3; r++) begin
         step_a(1'b1, w4(n), 1'b0); n += 4;
         total++; if (level_a !== 5'd4) begin bad++; $display("FAIL wrap_lvl r=%0d got=%0d exp=4", r, level_a); end
         step_a(1'b1, w4(n), 1'b1); n += 4;
         total++; if (data_out_a !== 8'(e) || level_a !== 5'd7) begin
            bad++; $display("FAIL wrap_rw r=%0d got=%h/%0d exp=%h/7", r, data_out_a, level_a, 8'(e)); end
         e++;
         for (int j = 0; j < 7; j++) begin
            step_a(1'b0, 32'h0, 1'b1);
            total++; if (data_out_a !== 8'(e) || level_a !== 5'(6 - j)) begin
               bad++; $display("FAIL wrap_rd r=%0d j=%0d got=%h/%0d exp=%h/%0d", r, j, data_out_a, level_a, 8'(e), 6 - j); end
            e++;
         end
      end
   endtask

   task automatic test_big_endian();
      logic [31:0] exp_t [4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
      for (int i = 0; i < 16; i++) step_b(1'b1, 8'(i), 1'b0);
      total++; if (level_b !== 5'd16 || full_b !== 1'b1) begin
         bad++; $display("FAIL be_fill got=%0d/%b exp=16/1", level_b, full_b); end
      for (int i = 0; i < 4; i++) begin
         step_b(1'b0, 8'h0, 1'b1);
         total++; if (data_out_b !== exp_t[i] || level_b !== 5'(12 - 4 * i)) begin
            bad++; $display("FAIL be_read i=%0d got=%h/%0d exp=%h/%0d", i, data_out_b, level_b, exp_t[i], 12 - 4 * i); end
      end
      total++; if (empty_b !== 1'b1) begin bad++; $display("FAIL be_empty got=%b exp=1", empty_b); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) step_a(1'b1, w4(8'hA0 + 4 * k), 1'b0);
      for (int i = 0; i < 4; i++) step_a(1'b0, 32'h0, 1'b1);
      total++; if (level_a !== 5'd8 || data_out_a !== 8'hA3 || ae_a !== 1'b0 || af_a !== 1'b0) begin
         bad++; $display("FAIL mid_pre got=%0d/%h/%b%b exp=8/a3/00", level_a, data_out_a, ae_a, af_a); end
      rst = 1'b1;
      step_a(1'b1, 32'h55555555, 1'b0);
      rst = 1'b0;
      total++; if (level_a !== 5'd0 || empty_a !== 1'b1 || data_out_a !== 8'h00 || ov_a !== 1'b0) begin
         bad++; $display("FAIL mid_rst got=%0d/%b/%h/%b exp=0/1/00/0", level_a, empty_a, data_out_a, ov_a); end
      step_a(1'b0, 32'h0, 1'b1);
      total++; if (uf_a !== 1'b1 || level_a !== 5'd0) begin
         bad++; $display("FAIL mid_after got=%b/%0d exp=1/0", uf_a, level_a); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow_underflow();
      test_wraparound();
      test_big_endian();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
